// File: rtl/cla8_mw_add_ctrl_pkg.sv
// Shared types for the multi-word CLA add/sub sequencer: FSM states, slice width, overflow helper.
package cla8_mw_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SLICE_W = 8;

  // Two's-complement overflow: operands agree in sign but the result does not.
  function automatic logic calc_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/cla8_mw_add_ctrl_if.sv
// Operand request, CLA slice and result handshake bundle; slave = the sequencer, master = its environment.
interface cla8_mw_add_ctrl_if
  import cla8_mw_pkg::*;
#(
  parameter int WORDS = 4
);
  localparam int W = SLICE_W * WORDS;

  logic               in_valid;
  logic               in_ready;
  logic [W-1:0]       a;
  logic [W-1:0]       b;
  logic               cin;
  logic               op_sub;
  logic [SLICE_W-1:0] slice_a;
  logic [SLICE_W-1:0] slice_b;
  logic               slice_cin;
  logic [SLICE_W-1:0] slice_sum;
  logic               slice_cout;
  logic               out_valid;
  logic               out_ready;
  logic [W-1:0]       sum;
  logic               cout;
  logic               ovf;

  modport slave (
    input  in_valid, a, b, cin, op_sub, slice_sum, slice_cout, out_ready,
    output in_ready, slice_a, slice_b, slice_cin, out_valid, sum, cout, ovf
  );

  modport master (
    output in_valid, a, b, cin, op_sub, slice_sum, slice_cout, out_ready,
    input  in_ready, slice_a, slice_b, slice_cin, out_valid, sum, cout, ovf
  );

endinterface

// File: rtl/cla8_mw_add_ctrl_slice_mux.sv
// Combinational byte selector feeding the external CLA slice; forces zero when not running.
module cla8_mw_slice_mux
  import cla8_mw_pkg::*;
#(
  parameter int WORDS = 4,
  parameter int IDX_W = 2
) (
  input  logic                       i_en,
  input  logic [SLICE_W*WORDS-1:0]   i_a,
  input  logic [SLICE_W*WORDS-1:0]   i_b,
  input  logic [IDX_W-1:0]           i_idx,
  output logic [SLICE_W-1:0]         o_a,
  output logic [SLICE_W-1:0]         o_b
);

  always_comb begin
    o_a = '0;
    o_b = '0;
    if (i_en) begin
      o_a = i_a[SLICE_W*i_idx +: SLICE_W];
      o_b = i_b[SLICE_W*i_idx +: SLICE_W];
    end
  end

endmodule

// File: rtl/cla8_mw_add_ctrl.sv
// WORDS*8-bit add/sub by time-sharing one 8-bit CLA slice; result valid WORDS edges after accept, held until out_ready.
// Optional CLA8_MW_OP_COUNT_EN adds a saturating op_count of completed result handshakes.
module cla8_mw_add_ctrl
  import cla8_mw_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cla8_mw_add_ctrl_if.slave    bus
`ifdef CLA8_MW_OP_COUNT_EN
  ,
  output logic [15:0]          op_count
`endif
);

  localparam int W     = SLICE_W * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  state_t             r_state;
  state_t             w_next;
  logic [W-1:0]       r_a;
  logic [W-1:0]       r_b_eff;
  logic [W-1:0]       r_sum;
  logic               r_carry;
  logic               r_cout;
  logic               r_ovf;
  logic [IDX_W-1:0]   r_idx;
  logic               w_accept;
  logic               w_run;
  logic               w_last;

  assign w_accept = (r_state == IDLE) && bus.in_valid;
  assign w_last   = (r_idx == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    w_run         = 1'b0;
    case (r_state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) w_next = RUN;
      end
      RUN: begin
        w_run = 1'b1;
        if (w_last) w_next = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Subtract is A + ~B + 1, so the inversion and forced carry happen once at accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b_eff <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_idx   <= '0;
    end else if (w_accept) begin
      r_a     <= bus.a;
      r_b_eff <= bus.op_sub ? ~bus.b : bus.b;
      r_carry <= bus.op_sub | bus.cin;
      r_sum   <= '0;
      r_idx   <= '0;
    end else if (w_run) begin
      r_sum[SLICE_W*r_idx +: SLICE_W] <= bus.slice_sum;
      r_carry <= bus.slice_cout;
      if (w_last) begin
        r_cout <= bus.slice_cout;
        r_ovf  <= calc_ovf(r_a[W-1], r_b_eff[W-1], bus.slice_sum[SLICE_W-1]);
        r_idx  <= '0;
      end else begin
        r_idx  <= r_idx + 1'b1;
      end
    end
  end

  cla8_mw_slice_mux #(
    .WORDS (WORDS),
    .IDX_W (IDX_W)
  ) u_slice_mux (
    .i_en  (w_run),
    .i_a   (r_a),
    .i_b   (r_b_eff),
    .i_idx (r_idx),
    .o_a   (bus.slice_a),
    .o_b   (bus.slice_b)
  );

  assign bus.slice_cin = w_run & r_carry;
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
  assign bus.ovf       = r_ovf;

`ifdef CLA8_MW_OP_COUNT_EN
  logic [15:0] r_op_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_count <= '0;
    end else if ((r_state == DONE) && bus.out_ready && (r_op_count != 16'hFFFF)) begin
      r_op_count <= r_op_count + 16'd1;
    end
  end

  assign op_count = r_op_count;
`endif

endmodule

// File: tb/tb_cla8_mw_add_ctrl.sv
// Directed bench for cla8_mw_add_ctrl (WORDS=4) with an ideal 8-bit adder standing in for the CLA slice.
module tb_cla8_mw_add_ctrl;
  import cla8_mw_pkg::*;

  localparam int WORDS = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cla8_mw_add_ctrl_if #(.WORDS(WORDS)) bus ();

  logic [8:0] slice_res;
  assign slice_res      = {1'b0, bus.slice_a} + {1'b0, bus.slice_b} + {8'd0, bus.slice_cin};
  assign bus.slice_sum  = slice_res[7:0];
  assign bus.slice_cout = slice_res[8];

`ifdef CLA8_MW_OP_COUNT_EN
  logic [15:0] op_count;
`endif

  cla8_mw_add_ctrl #(.WORDS(WORDS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus)
`ifdef CLA8_MW_OP_COUNT_EN
    ,
    .op_count (op_count)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] rec_a   [WORDS];
  logic [7:0] rec_b   [WORDS];
  logic       rec_cin [WORDS];
  int         lat;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one op from IDLE, record slice traffic per RUN cycle, optionally stall the result.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic sub, input logic [31:0] exp_sum,
                        input logic exp_cout, input logic exp_ovf, input int hold, input bit pulse);
    bus.a        = a;
    bus.b        = b;
    bus.cin      = cin;
    bus.op_sub   = sub;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      if (lat < WORDS) begin
        rec_a[lat]   = bus.slice_a;
        rec_b[lat]   = bus.slice_b;
        rec_cin[lat] = bus.slice_cin;
      end
      if (pulse && lat == 1) begin
        bus.in_valid = 1'b1;
        bus.a        = 32'hDEADBEEF;
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'(WORDS));
    for (int h = 0; h < hold; h++) begin
      check({tag, "_hold_vld"}, 64'(bus.out_valid), 64'd1);
      check({tag, "_hold_rdy"}, 64'(bus.in_ready), 64'd0);
      check({tag, "_hold_res"}, {31'd0, bus.cout, bus.ovf, bus.sum}, {31'd0, exp_cout, exp_ovf, exp_sum});
      @(posedge clk); #1;
    end
    check({tag, "_sum"},  64'(bus.sum),  64'(exp_sum));
    check({tag, "_cout"}, 64'(bus.cout), 64'(exp_cout));
    check({tag, "_ovf"},  64'(bus.ovf),  64'(exp_ovf));
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({tag, "_vld_drop"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_idle_rdy"}, 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.op_sub    = 1'b0;
    bus.out_ready = 1'b0;

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  64'(bus.in_ready),  64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_flags",     {30'd0, bus.cout, bus.ovf, bus.sum}, 64'd0);
    check("rst_slice",     {47'd0, bus.slice_cin, bus.slice_b, bus.slice_a}, 64'd0);
`ifdef CLA8_MW_OP_COUNT_EN
    check("rst_op_count", 64'(op_count), 64'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("t1", 32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0, 0, 1'b0);
    check("t1_byte0", {47'd0, rec_cin[0], rec_b[0], rec_a[0]}, {47'd0, 1'b0, 8'h01, 8'hFF});
    check("t1_cin1", 64'(rec_cin[1]), 64'd1);

    run_op("t2", 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 0, 1'b0);
    check("t2_ripple", {61'd0, rec_cin[1], rec_cin[2], rec_cin[3]}, 64'd7);

    run_op("t3", 32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 0, 1'b0);
    check("t3_b0",   64'(rec_b[0]),   64'hF8);
    check("t3_cin0", 64'(rec_cin[0]), 64'd1);
    check("t3_b3",   64'(rec_b[3]),   64'hFF);

    run_op("t4a", 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 0, 1'b0);
    run_op("t4b", 32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 0, 1'b0);

    run_op("t5", 32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0, 1'b0, 3, 1'b1);
    repeat (3) begin
      @(posedge clk); #1;
      check("t5_no_extra_op", {62'd0, bus.out_valid, bus.in_ready}, 64'd1);
    end

    // Abort mid-RUN: two bytes captured, then reset before the third edge.
    bus.a        = 32'h01010101;
    bus.b        = 32'h01010101;
    bus.cin      = 1'b0;
    bus.op_sub   = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("t6_partial", 64'(bus.sum), 64'h00000202);
    check("t6_idx2_slice", 64'(bus.slice_a), 64'h01);
    rst_n = 1'b0;
    #1;
    check("t6_arst_sum",   64'(bus.sum),       64'd0);
    check("t6_arst_vld",   64'(bus.out_valid), 64'd0);
    check("t6_arst_rdy",   64'(bus.in_ready),  64'd1);
    check("t6_arst_slice", {47'd0, bus.slice_cin, bus.slice_b, bus.slice_a}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("t6_post_rdy", 64'(bus.in_ready), 64'd1);
    run_op("t6", 32'h00000001, 32'h00000002, 1'b0, 1'b0, 32'h00000003, 1'b0, 1'b0, 0, 1'b0);
`ifdef CLA8_MW_OP_COUNT_EN
    check("t6_op_count", 64'(op_count), 64'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
